// File: rtl/acx_ipv4_hdr_checker.sv
// ---------------------------------------------------------------------------
// acx_ipv4_hdr_checker
//
// Purpose:
//   Receive-side IPv4 header checker. It monitors the MAC Rx packet stream
//   and does not forward it. From the 34-byte MAC+IP header it checks:
//     - the EtherType,
//     - the IP version and IHL,
//     - the ones-complement IP header checksum.
//   It then reports a per-packet result and keeps good/bad/runt counters.
//   On the wire, the first byte of each beat is the MSB of the data word.
//
// Parameters:
//   DATA_WIDTH  stream width in bits; only 256 is supported
//   CNT_WIDTH   width of each statistics counter (counters saturate)
//   ETH_TYPE    required EtherType value
//
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_tdata/i_tvalid/i_tlast/o_tready
//                     packet stream sink
//   i_cnt_clr         synchronous clear of all counters; wins over an increment
//   i_exp_dest_ip     expected destination IP; used only by the filter option
//   o_hdr_valid       1-cycle pulse; o_hdr_ok/o_cksum_err/o_src_ip/o_dest_ip
//                     are updated with it and held until the next pulse
//   o_good_cnt, o_bad_cnt, o_runt_cnt
//                     statistics counters
//
// Build option:
//   ACX_IPV4_CHK_DEST_FILTER_EN  when defined, a good header must also carry
//                                dest_addr == i_exp_dest_ip
// ---------------------------------------------------------------------------
module acx_ipv4_hdr_checker #(
    parameter int          DATA_WIDTH = 256,
    parameter int          CNT_WIDTH  = 32,
    parameter logic [15:0] ETH_TYPE   = 16'h0800
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tvalid,
    input  logic                  i_tlast,
    output logic                  o_tready,
    input  logic                  i_cnt_clr,
    input  logic [31:0]           i_exp_dest_ip,
    output logic                  o_hdr_valid,
    output logic                  o_hdr_ok,
    output logic                  o_cksum_err,
    output logic [31:0]           o_src_ip,
    output logic [31:0]           o_dest_ip,
    output logic [CNT_WIDTH-1:0]  o_good_cnt,
    output logic [CNT_WIDTH-1:0]  o_bad_cnt,
    output logic [CNT_WIDTH-1:0]  o_runt_cnt
);

    generate
        if (DATA_WIDTH != 256) begin : g_bad_width
            $error("acx_ipv4_hdr_checker: DATA_WIDTH must be 256");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_SOP  = 2'd0,
        S_HDR1 = 2'd1,
        S_PAY  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   tready_q;
    logic                   typeOk_q, verOk_q, ihlOk_q;
    logic [19:0]            hdrSum_q;
    logic [31:0]            srcCap_q;
    logic [15:0]            destHi_q;

    logic                   hdrValid_q, hdrOk_q, cksumErr_q;
    logic [31:0]            srcIp_q, destIp_q;
    logic [CNT_WIDTH-1:0]   goodCnt_q, badCnt_q, runtCnt_q;
    logic [CNT_WIDTH-1:0]   goodCnt_d, badCnt_d, runtCnt_d;

    logic                   beat;
    logic                   hdrEvent;
    logic                   runtEvent;
    logic [19:0]            beat0Sum;
    logic [19:0]            sumFinal;
    logic [16:0]            fold1;
    logic [16:0]            fold2;
    logic                   cksumPass;
    logic [31:0]            destIpNow;
    logic                   destOk;
    logic                   hdrOkNow;
    logic                   goodInc, badInc;

    assign beat      = i_tvalid & tready_q;
    assign hdrEvent  = beat & (state_q == S_HDR1);
    assign runtEvent = beat & (state_q == S_SOP) & i_tlast;

    // Beat 0 holds IP header bytes 14..31: nine 16-bit words, the first at
    // bits [143:128]. Nine 16-bit words plus the tenth from beat 1 stay
    // below 2^20, so a 20-bit accumulator never overflows.
    always_comb begin
        beat0Sum = '0;
        for (int k = 0; k < 9; k++) begin
            beat0Sum = beat0Sum + {4'b0000, i_tdata[143-16*k -: 16]};
        end
    end

    // Add the low half of dest_addr (bytes 32-33 = top of beat 1).
    // Two end-around-carry folds are enough for a 20-bit sum. After the
    // first fold a carry out of bit 16 leaves the low half small, so the
    // second fold cannot carry again.
    always_comb begin
        sumFinal  = hdrSum_q + {4'b0000, i_tdata[255:240]};
        fold1     = {13'b0, sumFinal[19:16]} + {1'b0, sumFinal[15:0]};
        fold2     = {16'b0, fold1[16]} + {1'b0, fold1[15:0]};
        cksumPass = (fold2[15:0] == 16'hFFFF);
        destIpNow = {destHi_q, i_tdata[255:240]};
    end

`ifdef ACX_IPV4_CHK_DEST_FILTER_EN
    logic unusedDataBits;
    assign unusedDataBits = ^i_tdata[239:160];
    assign destOk = (destIpNow == i_exp_dest_ip);
`else
    logic unusedDataBits;
    assign unusedDataBits = ^{i_tdata[239:160], i_exp_dest_ip};
    assign destOk = 1'b1;
`endif

    assign hdrOkNow = typeOk_q & verOk_q & ihlOk_q & cksumPass & destOk;
    assign goodInc  = hdrEvent & hdrOkNow;
    assign badInc   = (hdrEvent & ~hdrOkNow) | runtEvent;

    // Packet framing: the first beat carries the header, the second carries
    // the tail of dest_addr, and anything after that is payload.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SOP: begin
                if (beat && !i_tlast) begin
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (beat) begin
                    state_d = i_tlast ? S_SOP : S_PAY;
                end
            end
            S_PAY: begin
                if (beat && i_tlast) begin
                    state_d = S_SOP;
                end
            end
            default: state_d = S_SOP;
        endcase
    end

    // Saturating counter step. The clear has priority, so a clear that
    // arrives together with an increment leaves the counter at zero.
    function automatic logic [CNT_WIDTH-1:0] cntNext(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 inc,
        input logic                 clr
    );
        logic [CNT_WIDTH-1:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cur != {CNT_WIDTH{1'b1}})) begin
            nxt = cur + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    always_comb begin
        goodCnt_d = cntNext(goodCnt_q, goodInc,   i_cnt_clr);
        badCnt_d  = cntNext(badCnt_q,  badInc,    i_cnt_clr);
        runtCnt_d = cntNext(runtCnt_q, runtEvent, i_cnt_clr);
    end

    // State register. o_tready rises on the first clock after reset is
    // released.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_SOP;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= 1'b1;
        end
    end

    // Beat-0 captures: field checks are reduced to flags right away.
    // Only the partial checksum and the address fragments are kept for
    // beat 1.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            typeOk_q <= 1'b0;
            verOk_q  <= 1'b0;
            ihlOk_q  <= 1'b0;
            hdrSum_q <= '0;
            srcCap_q <= '0;
            destHi_q <= '0;
        end else if (beat && (state_q == S_SOP)) begin
            typeOk_q <= (i_tdata[159:144] == ETH_TYPE);
            verOk_q  <= (i_tdata[143:140] == 4'd4);
            ihlOk_q  <= (i_tdata[139:136] == 4'd5);
            hdrSum_q <= beat0Sum;
            srcCap_q <= i_tdata[47:16];
            destHi_q <= i_tdata[15:0];
        end
    end

    // Result registers. They update on the clock edge that takes beat 1
    // and then hold until the next header.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hdrValid_q <= 1'b0;
            hdrOk_q    <= 1'b0;
            cksumErr_q <= 1'b0;
            srcIp_q    <= '0;
            destIp_q   <= '0;
        end else begin
            hdrValid_q <= hdrEvent;
            if (hdrEvent) begin
                hdrOk_q    <= hdrOkNow;
                cksumErr_q <= ~cksumPass;
                srcIp_q    <= srcCap_q;
                destIp_q   <= destIpNow;
            end
        end
    end

    // Counters move on the same edge as the header result or the runt beat.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            goodCnt_q <= '0;
            badCnt_q  <= '0;
            runtCnt_q <= '0;
        end else begin
            goodCnt_q <= goodCnt_d;
            badCnt_q  <= badCnt_d;
            runtCnt_q <= runtCnt_d;
        end
    end

    assign o_tready    = tready_q;
    assign o_hdr_valid = hdrValid_q;
    assign o_hdr_ok    = hdrOk_q;
    assign o_cksum_err = cksumErr_q;
    assign o_src_ip    = srcIp_q;
    assign o_dest_ip   = destIp_q;
    assign o_good_cnt  = goodCnt_q;
    assign o_bad_cnt   = badCnt_q;
    assign o_runt_cnt  = runtCnt_q;

endmodule

// File: tb/tb_acx_ipv4_hdr_checker.sv
// ---------------------------------------------------------------------------
// tb_acx_ipv4_hdr_checker
//
// Self-checking bench for acx_ipv4_hdr_checker.
//   u_dut  uses the default parameters.
//   u_dut4 uses CNT_WIDTH=4 and receives the same stream, so counter
//          saturation can be observed.
// Header results are checked by a negedge monitor against a queue of
// expected results. Counters are checked against counts kept by the bench.
// ---------------------------------------------------------------------------
module tb_acx_ipv4_hdr_checker;

    localparam logic [31:0] DEF_SRC = 32'hC0A80102;
    localparam logic [31:0] DEF_DST = 32'hC0A80101;
    localparam logic [31:0] ALT_DST = 32'hC0A80104;

    logic         clk;
    logic         rstN;
    logic [255:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         cntClr;
    logic [31:0]  expDestIp;

    logic         oTready, oHdrValid, oHdrOk, oCksumErr;
    logic [31:0]  oSrcIp, oDestIp;
    logic [31:0]  oGoodCnt, oBadCnt, oRuntCnt;

    logic         unusedTready4, unusedHdrValid4, unusedHdrOk4, unusedCksumErr4;
    logic [31:0]  unusedSrcIp4, unusedDestIp4;
    logic [3:0]   oGoodCnt4, oBadCnt4, oRuntCnt4;

    int nCheck = 0;
    int nPass  = 0;
    int expGood = 0;
    int expBad  = 0;
    int expRunt = 0;

    typedef struct {
        logic [15:0] macType;
        logic [7:0]  verIhl;
        logic [15:0] len;
        logic [15:0] id;
        logic [15:0] flags;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] cksum;
        logic [31:0] src;
        logic [31:0] dst;
    } hdr_t;

    typedef struct {
        logic        ok;
        logic        ckErr;
        logic [31:0] src;
        logic [31:0] dst;
    } res_t;

    typedef struct {
        string       name;
        logic [15:0] macType;
        logic [7:0]  verIhl;
        logic [15:0] ckXor;
        logic        fixCk;
        int          nBeats;
        logic        expOk;
        logic        expCkErr;
    } vec_t;

    res_t expQ[$];

    acx_ipv4_hdr_checker u_dut (
        .i_clk         (clk),
        .i_reset_n     (rstN),
        .i_tdata       (tdata),
        .i_tvalid      (tvalid),
        .i_tlast       (tlast),
        .o_tready      (oTready),
        .i_cnt_clr     (cntClr),
        .i_exp_dest_ip (expDestIp),
        .o_hdr_valid   (oHdrValid),
        .o_hdr_ok      (oHdrOk),
        .o_cksum_err   (oCksumErr),
        .o_src_ip      (oSrcIp),
        .o_dest_ip     (oDestIp),
        .o_good_cnt    (oGoodCnt),
        .o_bad_cnt     (oBadCnt),
        .o_runt_cnt    (oRuntCnt)
    );

    acx_ipv4_hdr_checker #(.CNT_WIDTH(4)) u_dut4 (
        .i_clk         (clk),
        .i_reset_n     (rstN),
        .i_tdata       (tdata),
        .i_tvalid      (tvalid),
        .i_tlast       (tlast),
        .o_tready      (unusedTready4),
        .i_cnt_clr     (cntClr),
        .i_exp_dest_ip (expDestIp),
        .o_hdr_valid   (unusedHdrValid4),
        .o_hdr_ok      (unusedHdrOk4),
        .o_cksum_err   (unusedCksumErr4),
        .o_src_ip      (unusedSrcIp4),
        .o_dest_ip     (unusedDestIp4),
        .o_good_cnt    (oGoodCnt4),
        .o_bad_cnt     (oBadCnt4),
        .o_runt_cnt    (oRuntCnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Header as it appears on the wire: 34 bytes, byte 0 in the MSBs.
    function automatic logic [271:0] hdrVec(input hdr_t h);
        return {48'h020000000001, 48'h020000000002, h.macType, h.verIhl, 8'h00,
                h.len, h.id, h.flags, h.ttl, h.proto, h.cksum, h.src, h.dst};
    endfunction

    // Ones-complement sum of the ten IP header words (bytes 14..33).
    function automatic logic [15:0] ipSum(input logic [271:0] v);
        int unsigned s;
        s = 0;
        for (int w = 0; w < 10; w++) begin
            s += 32'(v[271-8*(14+2*w) -: 16]);
        end
        while (s > 32'hFFFF) begin
            s = (s & 32'hFFFF) + (s >> 16);
        end
        return s[15:0];
    endfunction

    function automatic hdr_t fixCk(input hdr_t h);
        hdr_t r;
        r = h;
        r.cksum = 16'h0000;
        r.cksum = ~ipSum(hdrVec(r));
        return r;
    endfunction

    // Header with a valid checksum that was worked out by hand.
    function automatic hdr_t defaultHdr();
        hdr_t h;
        h.macType = 16'h0800;
        h.verIhl  = 8'h45;
        h.len     = 16'h002E;
        h.id      = 16'h019A;
        h.flags   = 16'h4000;
        h.ttl     = 8'h40;
        h.proto   = 8'h11;
        h.cksum   = 16'hB5D1;
        h.src     = DEF_SRC;
        h.dst     = DEF_DST;
        return h;
    endfunction

    function automatic logic modelCkErr(input hdr_t h);
        return ipSum(hdrVec(h)) != 16'hFFFF;
    endfunction

    function automatic logic modelOk(input hdr_t h);
        logic ok;
        ok = (h.macType == 16'h0800) && (h.verIhl == 8'h45) && !modelCkErr(h);
`ifdef ACX_IPV4_CHK_DEST_FILTER_EN
        ok = ok && (h.dst == expDestIp);
`endif
        return ok;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = $urandom;
        end
        return r;
    endfunction

    function automatic longint sat4(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCheck++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One beat, optionally preceded by random-content stall cycles.
    task automatic applyStimulus(input logic [255:0] data, input logic last, input int gap, input logic clr);
        for (int g = 0; g < gap; g++) begin
            tvalid = 1'b0;
            tdata  = rnd256();
            tlast  = 1'($urandom_range(0, 1));
            cntClr = 1'b0;
            @(posedge clk);
            #1;
        end
        tvalid = 1'b1;
        tdata  = data;
        tlast  = last;
        cntClr = clr;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        cntClr = 1'b0;
    endtask

    task automatic sendPkt(input hdr_t h, input int nBeats, input int maxGap, input logic clrAtHdr,
                           input logic expOk, input logic expCkErr);
        logic [271:0] v;
        logic [255:0] d;
        res_t         r;
        int           gap;
        v = hdrVec(h);
        if (nBeats >= 2) begin
            r.ok    = expOk;
            r.ckErr = expCkErr;
            r.src   = h.src;
            r.dst   = h.dst;
            expQ.push_back(r);
        end
        for (int b = 0; b < nBeats; b++) begin
            if (b == 0) begin
                d = v[271:16];
            end else begin
                d = rnd256();
                if (b == 1) d[255:240] = v[15:0];
            end
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            applyStimulus(d, b == nBeats - 1, gap, clrAtHdr && (b == 1));
        end
        if (nBeats == 1) begin
            expBad++;
            expRunt++;
        end else if (expOk) begin
            expGood++;
        end else begin
            expBad++;
        end
        if (clrAtHdr) begin
            expGood = 0;
            expBad  = 0;
            expRunt = 0;
        end
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_good"},    64'(oGoodCnt),  64'(expGood));
        checkOutput({tag, "_bad"},     64'(oBadCnt),   64'(expBad));
        checkOutput({tag, "_runt"},    64'(oRuntCnt),  64'(expRunt));
        checkOutput({tag, "_good4"},   64'(oGoodCnt4), sat4(expGood));
        checkOutput({tag, "_bad4"},    64'(oBadCnt4),  sat4(expBad));
        checkOutput({tag, "_runt4"},   64'(oRuntCnt4), sat4(expRunt));
        checkOutput({tag, "_pending"}, 64'(expQ.size()), 64'd0);
    endtask

    // Every o_hdr_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        res_t e;
        if (rstN && oHdrValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedHdrValid", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("hdrOk",    64'(oHdrOk),    64'(e.ok));
                checkOutput("cksumErr", 64'(oCksumErr), 64'(e.ckErr));
                checkOutput("srcIp",    64'(oSrcIp),    64'(e.src));
                checkOutput("destIp",   64'(oDestIp),   64'(e.dst));
            end
        end
    end

    initial begin
        vec_t         vecs[9];
        hdr_t         h;
        logic [271:0] v;
        logic [255:0] d;
        res_t         r;
        int           nb;

        vecs[0] = '{"good3",   16'h0800, 8'h45, 16'h0000, 1'b0, 3, 1'b1, 1'b0};
        vecs[1] = '{"ckXor1",  16'h0800, 8'h45, 16'h0001, 1'b0, 3, 1'b0, 1'b1};
        vecs[2] = '{"ipv6",    16'h86DD, 8'h45, 16'h0000, 1'b1, 3, 1'b0, 1'b0};
        vecs[3] = '{"runt",    16'h0800, 8'h45, 16'h0000, 1'b0, 1, 1'b0, 1'b0};
        vecs[4] = '{"good2",   16'h0800, 8'h45, 16'h0000, 1'b0, 2, 1'b1, 1'b0};
        vecs[5] = '{"ver6",    16'h0800, 8'h65, 16'h0000, 1'b1, 3, 1'b0, 1'b0};
        vecs[6] = '{"ihl6",    16'h0800, 8'h46, 16'h0000, 1'b1, 2, 1'b0, 1'b0};
        vecs[7] = '{"ckFlip",  16'h0800, 8'h45, 16'hFFFF, 1'b0, 4, 1'b0, 1'b1};
        vecs[8] = '{"good5",   16'h0800, 8'h45, 16'h0000, 1'b0, 5, 1'b1, 1'b0};

        rstN      = 1'b1;
        tvalid    = 1'b0;
        tlast     = 1'b0;
        tdata     = '0;
        cntClr    = 1'b0;
        expDestIp = DEF_DST;
        #2 rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rstTready",   64'(oTready),   64'd0);
        checkOutput("rstHdrValid", 64'(oHdrValid), 64'd0);
        checkOutput("rstHdrOk",    64'(oHdrOk),    64'd0);
        checkOutput("rstCksumErr", 64'(oCksumErr), 64'd0);
        checkOutput("rstSrcIp",    64'(oSrcIp),    64'd0);
        checkOutput("rstDestIp",   64'(oDestIp),   64'd0);
        checkCounters("rst");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("readyAfterRst", 64'(oTready), 64'd1);

        // Result timing on a 3-beat good packet.
        $display("[TB] default packet latency");
        h = defaultHdr();
        v = hdrVec(h);
        r = '{1'b1, 1'b0, DEF_SRC, DEF_DST};
        expQ.push_back(r);
        applyStimulus(v[271:16], 1'b0, 0, 1'b0);
        @(negedge clk);
        checkOutput("t1NoValidAfterBeat0", 64'(oHdrValid), 64'd0);
        d = rnd256();
        d[255:240] = v[15:0];
        applyStimulus(d, 1'b0, 0, 1'b0);
        @(negedge clk);
        checkOutput("t1ValidAfterBeat1", 64'(oHdrValid), 64'd1);
        checkOutput("t1SrcIp", 64'(oSrcIp), 64'hC0A80102);
        applyStimulus(rnd256(), 1'b1, 0, 1'b0);
        @(negedge clk);
        checkOutput("t1PulseWidth", 64'(oHdrValid), 64'd0);
        checkOutput("t1SrcHeld",    64'(oSrcIp),    64'hC0A80102);
        expGood++;
        idle(2);
        checkCounters("t1");

        $display("[TB] vector table");
        foreach (vecs[i]) begin
            h = defaultHdr();
            h.macType = vecs[i].macType;
            h.verIhl  = vecs[i].verIhl;
            if (vecs[i].fixCk) h = fixCk(h);
            h.cksum = h.cksum ^ vecs[i].ckXor;
            sendPkt(h, vecs[i].nBeats, 1, 1'b0, vecs[i].expOk, vecs[i].expCkErr);
            idle(2);
            checkCounters(vecs[i].name);
        end

        $display("[TB] back-to-back, clear, saturation");
        idle(1);
        cntClr = 1'b1;
        @(posedge clk);
        #1;
        cntClr  = 1'b0;
        expGood = 0;
        expBad  = 0;
        expRunt = 0;
        h = defaultHdr();
        for (int i = 0; i < 10; i++) begin
            sendPkt(h, 2, 3, 1'b0, 1'b1, 1'b0);
        end
        idle(2);
        checkCounters("tenGood");
        sendPkt(h, 2, 0, 1'b1, 1'b1, 1'b0);
        idle(2);
        checkCounters("clrWins");
        for (int i = 0; i < 20; i++) begin
            sendPkt(h, 2, 0, 1'b0, 1'b1, 1'b0);
        end
        idle(2);
        checkCounters("saturate");

        $display("[TB] randomized packets");
        for (int i = 0; i < 60; i++) begin
            h = defaultHdr();
            h.len   = 16'($urandom_range(20, 1500));
            h.id    = 16'($urandom);
            h.flags = 16'($urandom) & 16'h7FFF;
            h.ttl   = 8'($urandom);
            h.proto = 8'($urandom);
            h.src   = $urandom;
            h.dst   = ($urandom_range(0, 1) != 0) ? expDestIp : $urandom;
            h = fixCk(h);
            case ($urandom_range(0, 7))
                0: h.cksum   = h.cksum ^ 16'(1 << $urandom_range(0, 15));
                1: h.macType = 16'h86DD;
                2: h.verIhl  = 8'h65;
                3: h.verIhl  = 8'h4F;
                default: ;
            endcase
            nb = int'($urandom_range(1, 4));
            sendPkt(h, nb, 2, 1'b0, modelOk(h), modelCkErr(h));
        end
        idle(2);
        checkCounters("random");

        $display("[TB] reset mid-packet");
        h = defaultHdr();
        v = hdrVec(h);
        applyStimulus(v[271:16], 1'b0, 0, 1'b0);
        rstN = 1'b0;
        #2;
        expQ.delete();
        expGood = 0;
        expBad  = 0;
        expRunt = 0;
        checkOutput("midRstTready",   64'(oTready),   64'd0);
        checkOutput("midRstHdrValid", 64'(oHdrValid), 64'd0);
        checkCounters("midRst");
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        sendPkt(h, 3, 0, 1'b0, 1'b1, 1'b0);
        idle(2);
        checkCounters("afterRst");
        expDestIp = ALT_DST;
`ifdef ACX_IPV4_CHK_DEST_FILTER_EN
        sendPkt(h, 3, 0, 1'b0, 1'b0, 1'b0);
`else
        sendPkt(h, 3, 0, 1'b0, 1'b1, 1'b0);
`endif
        idle(2);
        checkCounters("destFilter");
        expDestIp = DEF_DST;

        $display("%0d/%0d checks passed", nPass, nCheck);
        $finish;
    end

endmodule
